// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-bank writeback controller.
package wb_pkg;

   localparam int AWIDTH_DEF     = 3;
   localparam int DWIDTH_DEF     = 8;
   localparam int FIFO_DEPTH_DEF = 2;
   localparam int REG_COUNT      = 2 ** AWIDTH_DEF;

   typedef enum logic [1:0] {
      WB_SRC_NONE,
      WB_SRC_ALU,
      WB_SRC_LOAD
   } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering load returns until the bank write port is free.
module wb_fifo
   import wb_pkg::*;
#(
   parameter type req_t = logic [10:0],
   parameter int  DEPTH = FIFO_DEPTH_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  req_t push_data,
   input  logic pop,
   output logic full,
   output logic empty,
   output req_t head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   req_t          mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // NOTE: storage is deliberately not reset; count gates every read, so
   // stale entries are never observed and the array stays plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: merges ALU and load results onto the bank write port,
// tracks outstanding loads and bypasses the in-flight write onto the read path.
module regfile_wb_ctrl
   import wb_pkg::*;
#(
   parameter int AWIDTH     = AWIDTH_DEF,
   parameter int DWIDTH     = DWIDTH_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 alu_valid,
   input  logic [AWIDTH-1:0]    alu_rd,
   input  logic [DWIDTH-1:0]    alu_data,
   input  logic                 ld_issue,
   input  logic [AWIDTH-1:0]    ld_issue_rd,
   input  logic                 ld_valid,
   output logic                 ld_ready,
   input  logic [AWIDTH-1:0]    ld_rd,
   input  logic [DWIDTH-1:0]    ld_data,
   input  logic [AWIDTH-1:0]    raddr1,
   input  logic [AWIDTH-1:0]    raddr2,
   input  logic [DWIDTH-1:0]    rf_rdata1,
   input  logic [DWIDTH-1:0]    rf_rdata2,
   output logic [DWIDTH-1:0]    rdata1,
   output logic [DWIDTH-1:0]    rdata2,
   output logic                 hazard,
   output logic [2**AWIDTH-1:0] pending,
   output logic                 wen,
   output logic [AWIDTH-1:0]    waddr,
   output logic [DWIDTH-1:0]    wdata
);

   localparam int NREGS = 2 ** AWIDTH;

   typedef struct packed {
      logic [AWIDTH-1:0] rd;
      logic [DWIDTH-1:0] data;
   } wb_req_t;

   wb_src_e          src;
   wb_req_t          sel;
   wb_req_t          ld_req;
   wb_req_t          fifo_head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   logic [NREGS-1:0] pending_next;

   assign ld_ready = !fifo_full;
   assign ld_req   = '{rd: ld_rd, data: ld_data};

   wb_fifo #(
      .req_t (wb_req_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ld_valid && ld_ready),
      .push_data (ld_req),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      src      = WB_SRC_NONE;
      sel      = '0;
      fifo_pop = 1'b0;
      if (alu_valid) begin
         src = WB_SRC_ALU;
         sel = '{rd: alu_rd, data: alu_data};
      end else if (!fifo_empty) begin
         src      = WB_SRC_LOAD;
         sel      = fifo_head;
         fifo_pop = 1'b1;
      end
   end

   // Clear before set so a same-cycle issue to the retiring rd keeps it pending.
   always_comb begin
      pending_next = pending;
      if (src == WB_SRC_LOAD) pending_next[sel.rd] = 1'b0;
      if (ld_issue)           pending_next[ld_issue_rd] = 1'b1;
      pending_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wen     <= 1'b0;
         waddr   <= '0;
         wdata   <= '0;
         pending <= '0;
      end else begin
         wen <= (src != WB_SRC_NONE) && (sel.rd != '0);
         if (src != WB_SRC_NONE) begin
            waddr <= sel.rd;
            wdata <= sel.data;
         end
         pending <= pending_next;
      end
   end

   function automatic logic [DWIDTH-1:0] bypass(input logic [AWIDTH-1:0] addr,
                                                 input logic [DWIDTH-1:0] rf);
      if (addr == '0)                 return '0;
      else if (wen && waddr == addr)  return wdata;
      else                            return rf;
   endfunction

   assign rdata1 = bypass(raddr1, rf_rdata1);
   assign rdata2 = bypass(raddr2, rf_rdata2);
   assign hazard = (raddr1 != '0 && pending[raddr1]) ||
                   (raddr2 != '0 && pending[raddr2]);

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed self-checking bench for regfile_wb_ctrl (default parameters).
module tb_regfile_wb_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       alu_valid, ld_issue, ld_valid, ld_ready;
   logic [2:0] alu_rd, ld_issue_rd, ld_rd, raddr1, raddr2, waddr;
   logic [7:0] alu_data, ld_data, rf_rdata1, rf_rdata2, rdata1, rdata2, wdata;
   logic [7:0] pending;
   logic       hazard, wen;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   regfile_wb_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .ld_issue    (ld_issue),
      .ld_issue_rd (ld_issue_rd),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_rd       (ld_rd),
      .ld_data     (ld_data),
      .raddr1      (raddr1),
      .raddr2      (raddr2),
      .rf_rdata1   (rf_rdata1),
      .rf_rdata2   (rf_rdata2),
      .rdata1      (rdata1),
      .rdata2      (rdata2),
      .hazard      (hazard),
      .pending     (pending),
      .wen         (wen),
      .waddr       (waddr),
      .wdata       (wdata)
   );

   typedef struct {
      logic       alu_valid;
      logic [2:0] alu_rd;
      logic [7:0] alu_data;
      logic [2:0] raddr1;
      logic [7:0] rf1;
      logic       exp_wen;
      logic [2:0] exp_waddr;
      logic [7:0] exp_wdata;
      logic [7:0] exp_rdata1;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{1'b1, 3'd3, 8'h5A, 3'd3, 8'h11, 1'b1, 3'd3, 8'h5A, 8'h5A};
      vecs[1] = '{1'b1, 3'd4, 8'h77, 3'd3, 8'h22, 1'b1, 3'd4, 8'h77, 8'h22};
      vecs[2] = '{1'b1, 3'd0, 8'hFF, 3'd0, 8'hFF, 1'b0, 3'd0, 8'hFF, 8'h00};
      vecs[3] = '{1'b0, 3'd6, 8'h99, 3'd6, 8'h33, 1'b0, 3'd0, 8'hFF, 8'h33};
      vecs[4] = '{1'b1, 3'd7, 8'h01, 3'd7, 8'h44, 1'b1, 3'd7, 8'h01, 8'h01};

      rst_n = 1'b0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      ld_issue = 0; ld_issue_rd = 0; ld_valid = 0; ld_rd = 0; ld_data = 0;
      raddr1 = 0; raddr2 = 0; rf_rdata1 = 8'hFF; rf_rdata2 = 8'h00;
      #22 rst_n = 1'b1;
      #1;
      check("reset_wen", wen, 0);
      check("reset_pending", pending, 0);
      check("reset_ld_ready", ld_ready, 1);
      check("reset_hazard", hazard, 0);
      check("reset_rdata1_x0", rdata1, 8'h00);

      // ALU write and bypass vectors
      step();
      for (int i = 0; i < 5; i++) begin
         alu_valid = vecs[i].alu_valid;
         alu_rd    = vecs[i].alu_rd;
         alu_data  = vecs[i].alu_data;
         raddr1    = vecs[i].raddr1;
         rf_rdata1 = vecs[i].rf1;
         step();
         alu_valid = 1'b0;
         #1;
         check($sformatf("vec%0d_wen", i), wen, vecs[i].exp_wen);
         check($sformatf("vec%0d_waddr", i), waddr, vecs[i].exp_waddr);
         check($sformatf("vec%0d_wdata", i), wdata, vecs[i].exp_wdata);
         check($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].exp_rdata1);
      end
      raddr1 = 0;

      // Load vs ALU priority
      ld_issue = 1; ld_issue_rd = 3'd5; raddr2 = 3'd5;
      step();
      ld_issue = 0;
      #1;
      check("prio_pending5", pending, 8'h20);
      check("prio_hazard_set", hazard, 1);
      ld_valid = 1; ld_rd = 3'd5; ld_data = 8'hC3;
      alu_valid = 1; alu_rd = 3'd1; alu_data = 8'h10;
      #1 check("prio_ld_ready", ld_ready, 1);
      step();
      ld_valid = 0; alu_rd = 3'd2; alu_data = 8'h20;
      #1 check("prio_alu1_waddr", waddr, 3'd1);
      step();
      alu_valid = 0;
      #1;
      check("prio_alu2_waddr", waddr, 3'd2);
      check("prio_hazard_held", hazard, 1);
      step();
      check("prio_ld_wen", wen, 1);
      check("prio_ld_waddr", waddr, 3'd5);
      check("prio_ld_wdata", wdata, 8'hC3);
      check("prio_pending_clr", pending, 8'h00);
      check("prio_hazard_clr", hazard, 0);
      check("prio_bypass2", rdata2, 8'hC3);
      step();
      check("prio_idle_wen", wen, 0);
      raddr2 = 0;

      // Backpressure with FIFO ordering
      for (int i = 1; i <= 3; i++) begin
         ld_issue = 1; ld_issue_rd = 3'(i);
         step();
      end
      ld_issue = 0;
      check("bp_pending", pending, 8'h0E);
      alu_valid = 1; alu_rd = 3'd4; alu_data = 8'h40;
      ld_valid = 1; ld_rd = 3'd1; ld_data = 8'hA1;
      #1 check("bp_a0_ready", ld_ready, 1);
      step();
      alu_rd = 3'd5; alu_data = 8'h50; ld_rd = 3'd2; ld_data = 8'hA2;
      #1;
      check("bp_a1_ready", ld_ready, 1);
      check("bp_a1_waddr", waddr, 3'd4);
      step();
      alu_rd = 3'd6; alu_data = 8'h60; ld_rd = 3'd3; ld_data = 8'hA3;
      #1 check("bp_a2_ready", ld_ready, 0);
      step();
      alu_rd = 3'd7; alu_data = 8'h70;
      #1 check("bp_a3_ready", ld_ready, 0);
      step();
      alu_valid = 0;
      #1;
      check("bp_a4_ready", ld_ready, 0);
      check("bp_a4_waddr", waddr, 3'd7);
      step();
      check("bp_a5_ready", ld_ready, 1);
      check("bp_a5_waddr", waddr, 3'd1);
      check("bp_a5_wdata", wdata, 8'hA1);
      check("bp_a5_pending", pending, 8'h0C);
      step();
      ld_valid = 0;
      #1;
      check("bp_a6_waddr", waddr, 3'd2);
      check("bp_a6_wdata", wdata, 8'hA2);
      step();
      check("bp_a7_wen", wen, 1);
      check("bp_a7_waddr", waddr, 3'd3);
      check("bp_a7_wdata", wdata, 8'hA3);
      check("bp_a7_pending", pending, 8'h00);
      step();
      check("bp_drain_wen", wen, 0);

      // x0 handling
      alu_valid = 1; alu_rd = 3'd0; alu_data = 8'hFF;
      ld_valid = 1; ld_rd = 3'd0; ld_data = 8'hFF;
      step();
      alu_valid = 0; ld_valid = 0; ld_issue = 1; ld_issue_rd = 3'd0;
      #1 check("x0_alu_wen", wen, 0);
      step();
      ld_issue = 0;
      #1;
      check("x0_ld_wen", wen, 0);
      check("x0_pending", pending, 8'h00);
      step();
      check("x0_idle_wen", wen, 0);

      // Async reset mid-operation
      ld_issue = 1; ld_issue_rd = 3'd2;
      step();
      ld_issue_rd = 3'd5;
      step();
      ld_issue = 0;
      alu_valid = 1; alu_rd = 3'd1; alu_data = 8'h01;
      ld_valid = 1; ld_rd = 3'd2; ld_data = 8'h11;
      step();
      alu_rd = 3'd3; alu_data = 8'h03; ld_rd = 3'd5; ld_data = 8'h22;
      step();
      alu_valid = 0; ld_valid = 0;
      #1;
      check("rst_pre_ready", ld_ready, 0);
      check("rst_pre_pending", pending, 8'h24);
      check("rst_pre_wen", wen, 1);
      rst_n = 1'b0;
      #1;
      check("rst_async_wen", wen, 0);
      check("rst_async_pending", pending, 8'h00);
      check("rst_async_ready", ld_ready, 1);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("rst_post%0d_wen", i), wen, 0);
      end
      check("rst_post_pending", pending, 8'h00);
      check("rst_post_ready", ld_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
